// File: rtl/frame_writer_pkg.sv
// Shared definitions for the host-memory frame writer: geometry, FSM encodings,
// header layout and frame-ring address construction.
package frame_writer_pkg;

  localparam int CACHE_WIDTH      = 512;
  localparam int UMF_WIDTH        = 128;
  localparam int ADDR_WIDTH       = 32;
  localparam int LOG_FRAME_NUMBER = 2;
  localparam int LOG_FRAME_CHUNKS = 6;
  localparam int WORDS_PER_LINE   = CACHE_WIDTH / UMF_WIDTH;
  localparam int LOG_WORDS        = $clog2(WORDS_PER_LINE);
  localparam int BASE_WIDTH       = ADDR_WIDTH - LOG_FRAME_NUMBER - LOG_FRAME_CHUNKS;
  localparam int CHUNK_CNT_WIDTH  = LOG_FRAME_CHUNKS + 1;

  localparam logic [2:0] ST_IDLE         = 3'd0;
  localparam logic [2:0] ST_POLL_HEADER  = 3'd1;
  localparam logic [2:0] ST_WAIT_HEADER  = 3'd2;
  localparam logic [2:0] ST_FILL         = 3'd3;
  localparam logic [2:0] ST_WRITE_LINE   = 3'd4;
  localparam logic [2:0] ST_DRAIN        = 3'd5;
  localparam logic [2:0] ST_WRITE_HEADER = 3'd6;

  typedef struct packed {
    logic [CACHE_WIDTH-LOG_FRAME_CHUNKS-2:0] rsvd;
    logic [LOG_FRAME_CHUNKS-1:0]             count;
    logic                                    valid;
  } header_t;

  function automatic logic [CACHE_WIDTH-1:0] pack_header(input logic [LOG_FRAME_CHUNKS-1:0] count);
    header_t hdr;
    hdr       = '0;
    hdr.valid = 1'b1;
    hdr.count = count;
    return hdr;
  endfunction

  function automatic header_t unpack_header(input logic [CACHE_WIDTH-1:0] line);
    return header_t'(line);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] frame_addr(input logic [BASE_WIDTH-1:0]       base,
                                                       input logic [LOG_FRAME_NUMBER-1:0] frame,
                                                       input logic [LOG_FRAME_CHUNKS-1:0] chunk);
    return {base, frame, chunk};
  endfunction

endpackage

// File: rtl/frame_writer_if.sv
// Bus bundle between the frame writer, the UMF transmit stream and the
// read/write channel arbiter.
interface frame_writer_if;
  import frame_writer_pkg::*;

  logic [UMF_WIDTH-1:0]   tx_data;
  logic                   tx_enable;
  logic                   tx_rdy;
  logic                   rd_req;
  logic [ADDR_WIDTH-1:0]  rd_addr;
  logic                   rd_grant;
  logic                   rsp_valid;
  logic                   rsp_is_writer;
  logic [CACHE_WIDTH-1:0] rsp_data;
  logic                   wr_req;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [CACHE_WIDTH-1:0] wr_data;
  logic                   wr_grant;
  logic                   wr_ack;

  modport master (
    input  tx_data, tx_enable, rd_grant, rsp_valid, rsp_is_writer, rsp_data, wr_grant, wr_ack,
    output tx_rdy, rd_req, rd_addr, wr_req, wr_addr, wr_data
  );

  modport slave (
    output tx_data, tx_enable, rd_grant, rsp_valid, rsp_is_writer, rsp_data, wr_grant, wr_ack,
    input  tx_rdy, rd_req, rd_addr, wr_req, wr_addr, wr_data
  );

endinterface

// File: rtl/frame_writer_line_packer.sv
// Packs UMF words into a cache-line buffer, lane by lane; clr empties the line.
module frame_writer_line_packer
  import frame_writer_pkg::*;
(
  input  logic                   clk,
  input  logic                   resetb,
  input  logic                   clr,
  input  logic                   wr_en,
  input  logic [UMF_WIDTH-1:0]   data,
  output logic [CACHE_WIDTH-1:0] line,
  output logic                   full,
  output logic                   partial
);

  logic [LOG_WORDS-1:0]   word_idx_r;
  logic [CACHE_WIDTH-1:0] line_r;

  // lane write and word index advance; clearing wins over a write
  always_ff @(posedge clk) begin
    if (!resetb || clr) begin
      line_r     <= '0;
      word_idx_r <= '0;
    end else if (wr_en) begin
      line_r[word_idx_r*UMF_WIDTH +: UMF_WIDTH] <= data;
      word_idx_r <= word_idx_r + LOG_WORDS'(1);
    end
  end

  assign line    = line_r;
  assign full    = wr_en && (word_idx_r == LOG_WORDS'(WORDS_PER_LINE - 1));
  assign partial = (word_idx_r != '0);

endmodule

// File: rtl/frame_writer.sv
// Transmit-side frame writer: fills host-memory frame ring chunks with packed
// UMF lines, then publishes the frame by writing its header once data is acked.
module frame_writer
  import frame_writer_pkg::*;
#(
  parameter int FLUSH_TIMEOUT   = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  afu_en,
  input  logic [BASE_WIDTH-1:0] frame_base,
  frame_writer_if.master        bus,
  output logic [31:0]           dbg_state
);

  localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int IDLE_W = $clog2(FLUSH_TIMEOUT + 1);
  localparam logic [CHUNK_CNT_WIDTH-1:0] LAST_CHUNK = CHUNK_CNT_WIDTH'((1 << LOG_FRAME_CHUNKS) - 1);

  logic [2:0]                  state_r, state_s;
  logic [LOG_FRAME_NUMBER-1:0] frame_r, frame_s;
  logic [CHUNK_CNT_WIDTH-1:0]  chunk_r, chunk_s;
  logic [IDLE_W-1:0]           idle_r, idle_s;
  logic [OUT_W-1:0]            outst_r;
  logic                        flush_r, flush_s;
  logic                        srst_s, grant_s, ack_s;
  logic                        pack_wr_s, pack_clr_s, pack_full_s, pack_partial_s;
  logic [CACHE_WIDTH-1:0]      line_s;
  logic [LOG_FRAME_CHUNKS-1:0] hdr_cnt_s;
  header_t                     rsp_hdr_s;
  logic                        unused_hdr_s;

  assign srst_s    = !afu_en;
  assign grant_s   = bus.wr_grant && bus.wr_req;
  assign ack_s     = bus.wr_ack && (outst_r != '0);
  assign rsp_hdr_s = unpack_header(bus.rsp_data);
  assign hdr_cnt_s = LOG_FRAME_CHUNKS'(chunk_r - CHUNK_CNT_WIDTH'(1));
  assign unused_hdr_s = ^{rsp_hdr_s.rsvd, rsp_hdr_s.count};

  frame_writer_line_packer u_packer (
    .clk     (clk),
    .resetb  (resetb),
    .clr     (pack_clr_s),
    .wr_en   (pack_wr_s),
    .data    (bus.tx_data),
    .line    (line_s),
    .full    (pack_full_s),
    .partial (pack_partial_s)
  );

  // next-state and counter updates for the frame FSM
  always_comb begin
    state_s    = state_r;
    frame_s    = frame_r;
    chunk_s    = chunk_r;
    idle_s     = idle_r;
    flush_s    = flush_r;
    pack_wr_s  = 1'b0;
    pack_clr_s = srst_s;
    case (state_r)
      ST_IDLE: state_s = ST_POLL_HEADER;
      ST_POLL_HEADER: begin
        if (bus.rd_grant) state_s = ST_WAIT_HEADER;
        else              state_s = ST_POLL_HEADER;
      end
      ST_WAIT_HEADER: begin
        if (bus.rsp_valid && bus.rsp_is_writer) begin
          if (rsp_hdr_s.valid) begin
            state_s = ST_POLL_HEADER;
          end else begin
            state_s = ST_FILL;
            chunk_s = CHUNK_CNT_WIDTH'(1);
            idle_s  = '0;
            flush_s = 1'b0;
          end
        end else begin
          state_s = ST_WAIT_HEADER;
        end
      end
      ST_FILL: begin
        if (bus.tx_enable) begin
          pack_wr_s = 1'b1;
          idle_s    = '0;
          if (pack_full_s) state_s = ST_WRITE_LINE;
          else             state_s = ST_FILL;
        end else if (idle_r == IDLE_W'(FLUSH_TIMEOUT)) begin
          // an empty line with no chunks written yet is never published
          idle_s = '0;
          if (pack_partial_s) begin
            state_s = ST_WRITE_LINE;
            flush_s = 1'b1;
          end else if (chunk_r > CHUNK_CNT_WIDTH'(1)) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_FILL;
          end
        end else begin
          idle_s = idle_r + IDLE_W'(1);
        end
      end
      ST_WRITE_LINE: begin
        if (grant_s) begin
          pack_clr_s = 1'b1;
          idle_s     = '0;
          chunk_s    = chunk_r + CHUNK_CNT_WIDTH'(1);
          flush_s    = 1'b0;
          if ((chunk_r == LAST_CHUNK) || flush_r) state_s = ST_DRAIN;
          else                                    state_s = ST_FILL;
        end else begin
          state_s = ST_WRITE_LINE;
        end
      end
      ST_DRAIN: begin
        if (outst_r == '0) state_s = ST_WRITE_HEADER;
        else               state_s = ST_DRAIN;
      end
      ST_WRITE_HEADER: begin
        if (grant_s) begin
          frame_s = frame_r + LOG_FRAME_NUMBER'(1);
          chunk_s = '0;
          state_s = ST_POLL_HEADER;
        end else begin
          state_s = ST_WRITE_HEADER;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM and counter registers; afu_en low behaves like reset
  always_ff @(posedge clk) begin
    if (!resetb || srst_s) begin
      state_r <= ST_IDLE;
      frame_r <= '0;
      chunk_r <= '0;
      idle_r  <= '0;
      flush_r <= 1'b0;
    end else begin
      state_r <= state_s;
      frame_r <= frame_s;
      chunk_r <= chunk_s;
      idle_r  <= idle_s;
      flush_r <= flush_s;
    end
  end

  // outstanding write counter, saturating at zero on stray acks
  always_ff @(posedge clk) begin
    if (!resetb || srst_s) begin
      outst_r <= '0;
    end else begin
      case ({grant_s, ack_s})
        2'b10:   outst_r <= outst_r + OUT_W'(1);
        2'b01:   outst_r <= outst_r - OUT_W'(1);
        default: outst_r <= outst_r;
      endcase
    end
  end

  assign bus.tx_rdy  = (state_r == ST_FILL);
  assign bus.rd_req  = (state_r == ST_POLL_HEADER);
  assign bus.rd_addr = frame_addr(frame_base, frame_r, '0);
  assign bus.wr_req  = ((state_r == ST_WRITE_LINE) && (outst_r < OUT_W'(MAX_OUTSTANDING))) ||
                       (state_r == ST_WRITE_HEADER);
  assign bus.wr_addr = frame_addr(frame_base, frame_r,
                                  (state_r == ST_WRITE_HEADER) ? '0 : chunk_r[LOG_FRAME_CHUNKS-1:0]);
  assign bus.wr_data = (state_r == ST_WRITE_HEADER) ? pack_header(hdr_cnt_s) : line_s;
  assign dbg_state   = 32'({state_r, frame_r, chunk_r, outst_r});

endmodule

// File: tb/tb_frame_writer.sv
// Directed self-checking bench for frame_writer with a hand-driven host/arbiter.
module tb_frame_writer;
  import frame_writer_pkg::*;

  logic                  clk;
  logic                  resetb;
  logic                  afu_en;
  logic [BASE_WIDTH-1:0] frame_base;
  logic [31:0]           dbg_state;
  int                    tests_run;
  int                    tests_failed;
  int                    polls;

  frame_writer_if bus ();

  frame_writer dut (
    .clk        (clk),
    .resetb     (resetb),
    .afu_en     (afu_en),
    .frame_base (frame_base),
    .bus        (bus),
    .dbg_state  (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [CACHE_WIDTH-1:0] obs,
                          input logic [CACHE_WIDTH-1:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_WIDTH-1:0] exp_addr(input int f, input int c);
    logic [1:0] fb;
    logic [5:0] cb;
    fb = f[1:0];
    cb = c[5:0];
    return {24'h000100, fb, cb};
  endfunction

  function automatic logic [CACHE_WIDTH-1:0] exp_hdr(input int count);
    logic [CACHE_WIDTH-1:0] h;
    h      = '0;
    h[0]   = 1'b1;
    h[6:1] = count[5:0];
    return h;
  endfunction

  function automatic logic [CACHE_WIDTH-1:0] exp_line(input int w0, input int nwords);
    logic [CACHE_WIDTH-1:0] l;
    l = '0;
    for (int i = 0; i < nwords; i++) l[i*UMF_WIDTH +: UMF_WIDTH] = UMF_WIDTH'(w0 + i);
    return l;
  endfunction

  task automatic wait_rd_req();
    int n;
    n = 0;
    while (!bus.rd_req && n < 300) begin tick(); n++; end
    if (!bus.rd_req) check_eq("rd_req_timeout", 512'd0, 512'd1);
  endtask

  task automatic wait_wr_req();
    int n;
    n = 0;
    while (!bus.wr_req && n < 300) begin tick(); n++; end
    if (!bus.wr_req) check_eq("wr_req_timeout", 512'd0, 512'd1);
  endtask

  task automatic poll(input logic owned, input int fn);
    wait_rd_req();
    check_eq("poll_addr", 512'(bus.rd_addr), 512'(exp_addr(fn, 0)));
    bus.rd_grant = 1'b1;
    tick();
    bus.rd_grant      = 1'b0;
    polls++;
    bus.rsp_valid     = 1'b1;
    bus.rsp_is_writer = 1'b1;
    bus.rsp_data      = '0;
    bus.rsp_data[0]   = owned;
    tick();
    bus.rsp_valid     = 1'b0;
  endtask

  task automatic send_words(input int w0, input int nwords);
    for (int i = 0; i < nwords; i++) begin
      bus.tx_enable = 1'b1;
      bus.tx_data   = UMF_WIDTH'(w0 + i);
      tick();
    end
    bus.tx_enable = 1'b0;
  endtask

  task automatic grant_wr(input logic with_ack);
    bus.wr_grant = 1'b1;
    bus.wr_ack   = with_ack;
    tick();
    bus.wr_grant = 1'b0;
    bus.wr_ack   = 1'b0;
  endtask

  task automatic ack_one();
    bus.wr_ack = 1'b1;
    tick();
    bus.wr_ack = 1'b0;
  endtask

  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    polls             = 0;
    resetb            = 1'b0;
    afu_en            = 1'b1;
    frame_base        = 24'h000100;
    bus.tx_data       = '0;
    bus.tx_enable     = 1'b0;
    bus.rd_grant      = 1'b0;
    bus.rsp_valid     = 1'b0;
    bus.rsp_is_writer = 1'b0;
    bus.rsp_data      = '0;
    bus.wr_grant      = 1'b0;
    bus.wr_ack        = 1'b0;
    repeat (3) tick();
    check_eq("rst_tx_rdy", 512'(bus.tx_rdy), 512'd0);
    check_eq("rst_rd_req", 512'(bus.rd_req), 512'd0);
    check_eq("rst_wr_req", 512'(bus.wr_req), 512'd0);
    check_eq("rst_dbg", 512'(dbg_state), 512'd0);
    resetb = 1'b1;

    // poll retry: host owns the frame twice, then releases it
    poll(1'b1, 0);
    check_eq("retry1_tx_rdy", 512'(bus.tx_rdy), 512'd0);
    poll(1'b1, 0);
    check_eq("retry2_tx_rdy", 512'(bus.tx_rdy), 512'd0);
    poll(1'b0, 0);
    check_eq("poll_count", 512'(polls), 512'd3);
    check_eq("fill_tx_rdy", 512'(bus.tx_rdy), 512'd1);

    // full line 1..4 then partial line 5,6 flushed by timeout
    send_words(1, 4);
    check_eq("line1_wr_req", 512'(bus.wr_req), 512'd1);
    check_eq("line1_tx_rdy", 512'(bus.tx_rdy), 512'd0);
    check_eq("line1_addr", 512'(bus.wr_addr), 512'(exp_addr(0, 1)));
    check_eq("line1_data", bus.wr_data, exp_line(1, 4));
    grant_wr(1'b0);
    check_eq("line1_back_fill", 512'(bus.tx_rdy), 512'd1);
    send_words(5, 2);
    wait_wr_req();
    check_eq("line2_addr", 512'(bus.wr_addr), 512'(exp_addr(0, 2)));
    check_eq("line2_data", bus.wr_data, exp_line(5, 2));
    grant_wr(1'b0);
    check_eq("drain_outst", 512'(dbg_state[3:0]), 512'd2);
    ack_one();
    repeat (3) tick();
    check_eq("hdr_held_for_ack", 512'(bus.wr_req), 512'd0);
    ack_one();
    wait_wr_req();
    check_eq("hdr0_addr", 512'(bus.wr_addr), 512'(exp_addr(0, 0)));
    check_eq("hdr0_data", bus.wr_data, exp_hdr(2));
    grant_wr(1'b0);
    ack_one();

    // reset mid-frame via afu_en, restart at frame 0
    poll(1'b0, 1);
    send_words(16'h0100, 4);
    check_eq("mid_wr_req", 512'(bus.wr_req), 512'd1);
    afu_en = 1'b0;
    tick();
    check_eq("srst_wr_req", 512'(bus.wr_req), 512'd0);
    check_eq("srst_tx_rdy", 512'(bus.tx_rdy), 512'd0);
    check_eq("srst_dbg", 512'(dbg_state), 512'd0);
    afu_en = 1'b1;
    wait_rd_req();
    check_eq("reenable_poll_addr", 512'(bus.rd_addr), 512'(exp_addr(0, 0)));

    // five full frames around the ring
    for (int f = 0; f < 5; f++) begin
      int fn;
      fn = f % 4;
      poll(1'b0, fn);
      check_eq("frame_dbg", 512'(dbg_state[12:11]), 512'(fn));
      for (int l = 1; l < 64; l++) begin
        int w0;
        w0 = (f << 20) | (l << 8);
        send_words(w0, 4);
        wait_wr_req();
        check_eq("ring_line_addr", 512'(bus.wr_addr), 512'(exp_addr(fn, l)));
        if (l == 1 || l == 63) check_eq("ring_line_data", bus.wr_data, exp_line(w0, 4));
        grant_wr(1'b0);
        if (l < 63) ack_one();
      end
      repeat (3) tick();
      check_eq("ring_drain_state", 512'(dbg_state[15:13]), 512'd5);
      check_eq("ring_hdr_held", 512'(bus.wr_req), 512'd0);
      ack_one();
      wait_wr_req();
      check_eq("ring_hdr_addr", 512'(bus.wr_addr), 512'(exp_addr(fn, 0)));
      check_eq("ring_hdr_data", bus.wr_data, exp_hdr(63));
      grant_wr(1'b0);
      ack_one();
    end

    // backpressure: eight unacked writes stall the ninth
    poll(1'b0, 1);
    for (int l = 1; l <= 8; l++) begin
      send_words(l << 4, 4);
      wait_wr_req();
      grant_wr(1'b0);
    end
    send_words(16'h0900, 4);
    check_eq("bp_wr_req", 512'(bus.wr_req), 512'd0);
    tick();
    check_eq("bp_wr_req_hold", 512'(bus.wr_req), 512'd0);
    check_eq("bp_state", 512'(dbg_state[15:13]), 512'd4);
    check_eq("bp_outst", 512'(dbg_state[3:0]), 512'd8);
    ack_one();
    check_eq("bp_release", 512'(bus.wr_req), 512'd1);
    check_eq("bp_addr", 512'(bus.wr_addr), 512'(exp_addr(1, 9)));
    grant_wr(1'b1);
    check_eq("grant_ack_outst", 512'(dbg_state[3:0]), 512'd7);
    check_eq("grant_ack_chunk", 512'(dbg_state[10:4]), 512'd10);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
